// File: rtl/math_pkg.sv
// Shared math-block definitions: default datapath width and the divider FSM encoding.
package math_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, dvd} left, trial-subtract the divisor,
// and shift the resulting quotient bit into the low end of dvd.
module div_step
  import math_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The compare is WIDTH+1 bits wide so a carried-out bit still counts; when it fits,
  // the true difference is below the divisor, so the low WIDTH bits are exact.
  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    fits     = shifted >= {1'b0, dvs};
    diff     = shifted[WIDTH-1:0] - dvs;
    rem_next = fits ? diff : shifted[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first,
// with a divide-by-zero shortcut and back-to-back start from DONE.
module div_unit
  import math_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic [WIDTH-1:0] rem_next, dvd_next;
  logic             zero_pend;
  logic             accept, last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd      (dvd),
    .dvs      (dvs),
    .rem_next (rem_next),
    .dvd_next (dvd_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (zero_pend || last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // A zero divisor spends its single RUN cycle publishing the saturated result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      zero_pend   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt       <= '0;
      rem       <= '0;
      dvd       <= dividend;
      dvs       <= divisor;
      zero_pend <= (divisor == '0);
    end else if (state == RUN) begin
      if (zero_pend) begin
        quotient    <= '1;
        remainder   <= dvd;
        div_by_zero <= 1'b1;
      end else begin
        rem <= rem_next;
        dvd <= dvd_next;
        cnt <= cnt + 1'b1;
        if (last) begin
          quotient    <= dvd_next;
          remainder   <= rem_next;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed scenarios plus random operands
// compared against a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int vectors = 0;
  int miscompares = 0;

  div_unit #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic z, output int lat);
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; z = 1'b1; lat = 1;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = 16;
    end
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (lat = -1 on timeout).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output int lat, output int busy_cnt,
                       output logic [15:0] mid_q, output logic [15:0] mid_r,
                       output logic mid_z);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = 16'($urandom); divisor = 16'($urandom);
    mid_q = quotient; mid_r = remainder; mid_z = div_by_zero;
    lat = -1; busy_cnt = 0;
    for (int j = 0; j < 100; j++) begin
      if (done === 1'b1) begin lat = j; break; end
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h z=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    logic [15:0] mq, mr, eq, er; logic mz, ez; int lat, bc, elat;
    model(16'd1000, 16'd7, eq, er, ez, elat);
    do_op(16'd1000, 16'd7, lat, bc, mq, mr, mz);
    vectors++;
    if (lat !== elat || bc !== 16) begin
      miscompares++;
      $display("FAIL basic_timing: got lat=%0d busy_cycles=%0d expected lat=%0d busy_cycles=16", lat, bc, elat);
    end
    vectors++;
    if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      miscompares++;
      $display("FAIL basic_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
               quotient, remainder, div_by_zero, eq, er, ez);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq || remainder !== er) begin
      miscompares++;
      $display("FAIL basic_pulse_hold: got done=%b busy=%b q=%0d r=%0d expected done=0 busy=0 q=%0d r=%0d",
               done, busy, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_boundaries;
    logic [15:0] av[2] = '{16'hFFFF, 16'hFFFF};
    logic [15:0] bv[2] = '{16'h0001, 16'h8001};
    logic [15:0] mq, mr, eq, er; logic mz, ez; int lat, bc, elat;
    for (int i = 0; i < 2; i++) begin
      model(av[i], bv[i], eq, er, ez, elat);
      do_op(av[i], bv[i], lat, bc, mq, mr, mz);
      vectors++;
      if (lat !== elat || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
        miscompares++;
        $display("FAIL boundary_%0d: got lat=%0d q=%h r=%h z=%b expected lat=%0d q=%h r=%h z=%b",
                 i, lat, quotient, remainder, div_by_zero, elat, eq, er, ez);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    logic [15:0] mq, mr; logic mz; int lat, bc;
    do_op(16'd5, 16'd0, lat, bc, mq, mr, mz);
    vectors++;
    if (lat !== 1 || bc !== 1) begin
      miscompares++;
      $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d expected lat=1 busy_cycles=1", lat, bc);
    end
    vectors++;
    if (quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL dbz_result: got q=%h r=%0d z=%b expected q=ffff r=5 z=1", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    do_op(16'd9, 16'd3, lat, bc, mq, mr, mz);
    vectors++;
    if (mz !== 1'b1 || mq !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL dbz_hold_in_run: got q=%h z=%b expected q=ffff z=1", mq, mz);
    end
    vectors++;
    if (lat !== 16 || quotient !== 16'd3 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL after_dbz: got lat=%0d q=%0d r=%0d z=%b expected lat=16 q=3 r=0 z=0",
               lat, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat;
    dividend = 16'd3; divisor = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int j = 0; j < 100; j++) begin
      if (done === 1'b1) begin lat = j; break; end
      if (j == 4) begin start = 1'b1; dividend = 16'd100; divisor = 16'd9; end
      if (j == 5) start = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (lat !== 16 || quotient !== 16'd0 || remainder !== 16'd3 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d z=%b expected lat=16 q=0 r=3 z=0",
               lat, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int pulses[$];
    logic [15:0] eq, er; logic ez; int elat;
    model(16'd200, 16'd6, eq, er, ez, elat);
    dividend = 16'd200; divisor = 16'd6; start = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses.push_back(t);
        vectors++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
          miscompares++;
          $display("FAIL b2b_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
                   quotient, remainder, div_by_zero, eq, er, ez);
        end
        if (pulses.size() == 3) begin start = 1'b0; break; end
      end
    end
    start = 1'b0;
    vectors++;
    if (pulses.size() !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d pulses expected 3", pulses.size());
    end else begin
      vectors++;
      if (pulses[0] !== elat + 1 || pulses[1] - pulses[0] !== 17 || pulses[2] - pulses[1] !== 17) begin
        miscompares++;
        $display("FAIL b2b_spacing: got pulses at %0d,%0d,%0d expected %0d,%0d,%0d",
                 pulses[0], pulses[1], pulses[2], elat + 1, elat + 18, elat + 35);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    logic [15:0] mq, mr; logic mz; int lat, bc, spurious;
    dividend = 16'd1000; divisor = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
      miscompares++;
      $display("FAIL abort_clear: got busy=%b done=%b q=%0d r=%0d z=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    reset_n = 1'b1;
    spurious = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) spurious++;
    end
    vectors++;
    if (spurious !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", spurious);
    end
    do_op(16'd50, 16'd5, lat, bc, mq, mr, mz);
    vectors++;
    if (lat !== 16 || quotient !== 16'd10 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL after_abort: got lat=%0d q=%0d r=%0d z=%b expected lat=16 q=10 r=0 z=0",
               lat, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [15:0] a, b, mq, mr, eq, er, pq, pr;
    logic mz, ez, pz;
    int lat, bc, elat;
    pq = 16'd10; pr = 16'd0; pz = 1'b0;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1:       b = 16'h8000 | 16'($urandom);
        2:       b = 16'd1;
        default: b = 16'($urandom_range(1, 300));
      endcase
      if (i % 6 == 0) a = 16'hFFFF;
      model(a, b, eq, er, ez, elat);
      do_op(a, b, lat, bc, mq, mr, mz);
      vectors++;
      if (mq !== pq || mr !== pr || mz !== pz) begin
        miscompares++;
        $display("FAIL rand_hold_%0d: got q=%h r=%h z=%b expected q=%h r=%h z=%b", i, mq, mr, mz, pq, pr, pz);
      end
      vectors++;
      if (lat !== elat || bc !== elat || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
        miscompares++;
        $display("FAIL rand_%0d (%h/%h): got lat=%0d busy=%0d q=%h r=%h z=%b expected lat=%0d busy=%0d q=%h r=%h z=%b",
                 i, a, b, lat, bc, quotient, remainder, div_by_zero, elat, elat, eq, er, ez);
      end
      pq = eq; pr = er; pz = ez;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand and result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin a division; sampled on clk rising edge.
REQ-005 SHALL have port: dividend  input  WIDTH  unsigned numerator; sampled only on the accepting edge.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned denominator; sampled only on the accepting edge.
REQ-007 SHALL have port: busy  output  1  high while a division is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; results valid from this cycle onward.
REQ-009 SHALL have port: quotient  output  WIDTH  registered quotient of the last completed division.
REQ-010 SHALL have port: remainder  output  WIDTH  registered remainder of the last completed division.
REQ-011 SHALL have port: div_by_zero  output  1  high when the last completed division had divisor 0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; the accepting edge latches dividend and divisor, clears the iteration counter and the partial remainder.
REQ-014 SHALL ignore start while in RUN, with no effect on operands, counter or outputs.
REQ-015 SHALL perform restoring division in RUN, one quotient bit per clock, MSB first: shift {partial remainder, dividend} left 1, trial-subtract divisor, keep result and set quotient bit when no borrow.
REQ-016 SHALL use a (WIDTH+1)-bit trial subtraction so that divisors with MSB set produce correct results.
REQ-017 SHALL take exactly WIDTH RUN cycles: start accepted at edge k -> RUN at edges k+1..k+WIDTH -> DONE entered at edge k+WIDTH, done high for the cycle following that edge.
REQ-018 SHALL, for divisor 0 at the accepting edge, skip RUN: enter DONE at edge k+1 with quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-019 SHALL update quotient, remainder and div_by_zero only on entry to DONE; they hold their values through IDLE and through any subsequent RUN until the next DONE.
REQ-020 SHALL drive busy = 1 exactly while in RUN, and also in the cycle after accepting a divide-by-zero start.
REQ-021 SHALL drive done = 1 only in DONE; DONE lasts one cycle, then the FSM goes to IDLE unless start is high, in which case it goes directly to RUN (back-to-back operation).
REQ-022 SHALL clear div_by_zero on completion of any division with a non-zero divisor.

Reset
REQ-023 SHALL, on reset_n low, asynchronously force state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0, and clear the counter and internal operand registers.
REQ-024 SHALL abort an in-progress division on reset, with no done pulse afterwards; the first start after reset_n rises behaves as from power-up.

Structure
REQ-025 SHALL take the FSM state encoding and the default WIDTH constant from a shared package, math_pkg, which is reused by future math blocks.
REQ-026 SHALL use one combinational sub-module, div_step, for a single shift/trial-subtract iteration, instantiated once and used iteratively.
REQ-027 SHALL size the iteration counter as clog2(WIDTH)+1 bits and wrap it only via reset or start.

Verification
REQ-028 SHALL cover: dividend 1000, divisor 7, start one cycle -> busy for 16 cycles, then done pulse 17 cycles after start edge; quotient 142, remainder 6, div_by_zero 0.
REQ-029 SHALL cover: 0xFFFF / 0x0001 -> quotient 0xFFFF, remainder 0; and 0xFFFF / 0x8001 -> quotient 1, remainder 0x7FFE.
REQ-030 SHALL cover: 5 / 0 -> done pulse 2 cycles after start edge, quotient 0xFFFF, remainder 5, div_by_zero 1; a following 9 / 3 -> quotient 3, remainder 0, div_by_zero 0.
REQ-031 SHALL cover: 3 / 10 started, then start pulsed with 100 / 9 at cycle 5 of RUN -> second request ignored; result quotient 0, remainder 3.
REQ-032 SHALL cover: start held high continuously with 200 / 6 -> done pulses every 17 cycles, each with quotient 33, remainder 2.
REQ-033 SHALL cover: reset_n asserted at cycle 8 of RUN -> all outputs 0 immediately, with no done pulse; a new 50 / 5 then completes normally with quotient 10, remainder 0.
